// File: rtl/sram_xbar_arbiter.sv
// Rotating NCH x NCH crossbar between requester FSM ports and SRAM controller ports; one outstanding transaction per channel.
// Latency: 1 registered cycle request->controller and 1 registered cycle completion->requester; a rotation change waits for a full drain.
// Backpressure: o_stall_r per requester (busy, rotation pending, draining); a request arriving while stalled is discarded and flagged on o_drop_r.
module sram_xbar_arbiter #(
    parameter int NCH = 2,
    parameter int DW  = 16,
    parameter int AW  = 20,
    parameter int SW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     i_sel,
    output logic [SW-1:0]     o_sel_cur,
    output logic              o_switching,
    output logic              o_sel_err,
    input  logic [NCH-1:0]    i_mem_r,
    input  logic [NCH-1:0]    i_rw_r,
    input  logic [NCH*DW-1:0] i_din_r,
    input  logic [NCH*AW-1:0] i_adr_r,
    output logic [NCH-1:0]    o_stall_r,
    output logic [NCH-1:0]    o_drop_r,
    output logic [NCH-1:0]    o_ready_r,
    output logic [NCH*DW-1:0] o_dout_r,
    output logic [NCH-1:0]    o_mem_c,
    output logic [NCH-1:0]    o_rw_c,
    output logic [NCH*DW-1:0] o_din_c,
    output logic [NCH*AW-1:0] o_adr_c,
    input  logic [NCH-1:0]    i_ready_c,
    input  logic [NCH*DW-1:0] i_dout_c
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_t;

    localparam logic [SW:0] NCH_W = NCH[SW:0];

    state_t              state_q, state_d;
    logic [SW-1:0]       rot_q, rot_d;
    logic [NCH-1:0]      busy_q, busy_d;
    logic                sel_err_q, sel_err_d;
    logic [NCH-1:0]      drop_q, drop_d;
    logic [NCH-1:0]      ready_r_q, ready_r_d;
    logic [NCH*DW-1:0]   dout_r_q, dout_r_d;
    logic [NCH-1:0]      mem_c_q, mem_c_d;
    logic [NCH-1:0]      rw_c_q, rw_c_d;
    logic [NCH*DW-1:0]   din_c_q, din_c_d;
    logic [NCH*AW-1:0]   adr_c_q, adr_c_d;
    logic [NCH-1:0]      stall;
    logic                sel_ok;

    // Controller index serving requester k under rotation r.
    function automatic int ctrl_of(input int k, input logic [SW-1:0] r);
        return (k + int'(r)) % NCH;
    endfunction

    assign sel_ok = ({1'b0, i_sel} < NCH_W);

    // Stall everyone while a rotation is pending or draining, otherwise only busy channels; held low during reset.
    always_comb begin
        if ((state_q != ST_RUN) || (i_sel != rot_q)) begin
            stall = {NCH{1'b1}};
        end else begin
            stall = busy_q;
        end
        stall = stall & ~{NCH{rst}};
    end

    // Request routing, drop flagging and completion routing, all under the currently applied rotation.
    always_comb begin
        busy_d    = busy_q;
        drop_d    = '0;
        mem_c_d   = '0;
        rw_c_d    = rw_c_q;
        din_c_d   = din_c_q;
        adr_c_d   = adr_c_q;
        ready_r_d = '0;
        dout_r_d  = dout_r_q;
        for (int k = 0; k < NCH; k++) begin
            if (i_mem_r[k]) begin
                if (stall[k]) begin
                    drop_d[k] = 1'b1;
                end else begin
                    busy_d[k] = 1'b1;
                    for (int c = 0; c < NCH; c++) begin
                        if (c == ctrl_of(k, rot_q)) begin
                            mem_c_d[c]           = 1'b1;
                            rw_c_d[c]            = i_rw_r[k];
                            din_c_d[c*DW +: DW]  = i_din_r[k*DW +: DW];
                            adr_c_d[c*AW +: AW]  = i_adr_r[k*AW +: AW];
                        end
                    end
                end
            end
        end
        // A completion only counts when the mapped requester is actually waiting; a set busy bit never takes a new request, so clear and set cannot collide.
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if ((c == ctrl_of(k, rot_q)) && i_ready_c[c] && busy_q[k]) begin
                    ready_r_d[k]         = 1'b1;
                    dout_r_d[k*DW +: DW] = i_dout_c[c*DW +: DW];
                    busy_d[k]            = 1'b0;
                end
            end
        end
    end

    // Rotation FSM: RUN accepts traffic, DRAIN waits for all channels to go idle, SWITCH applies the new rotation.
    always_comb begin
        state_d   = state_q;
        rot_d     = rot_q;
        sel_err_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!sel_ok) begin
                    sel_err_d = 1'b1;
                end else if (i_sel != rot_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_sel == rot_q) begin
                    state_d = ST_RUN;
                end else if (busy_q == '0) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (sel_ok) begin
                    rot_d = i_sel;
                end
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            rot_q     <= '0;
            busy_q    <= '0;
            sel_err_q <= 1'b0;
            drop_q    <= '0;
            ready_r_q <= '0;
            dout_r_q  <= '0;
            mem_c_q   <= '0;
            rw_c_q    <= '0;
            din_c_q   <= '0;
            adr_c_q   <= '0;
        end else begin
            state_q   <= state_d;
            rot_q     <= rot_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
            drop_q    <= drop_d;
            ready_r_q <= ready_r_d;
            dout_r_q  <= dout_r_d;
            mem_c_q   <= mem_c_d;
            rw_c_q    <= rw_c_d;
            din_c_q   <= din_c_d;
            adr_c_q   <= adr_c_d;
        end
    end

    assign o_sel_cur   = rot_q;
    assign o_switching = (state_q != ST_RUN);
    assign o_sel_err   = sel_err_q;
    assign o_stall_r   = stall;
    assign o_drop_r    = drop_q;
    assign o_ready_r   = ready_r_q;
    assign o_dout_r    = dout_r_q;
    assign o_mem_c     = mem_c_q;
    assign o_rw_c      = rw_c_q;
    assign o_din_c     = din_c_q;
    assign o_adr_c     = adr_c_q;

endmodule
